mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle ARM core's unified instruction/data memory port.
- Replaces the zero-latency combinational memory model with a registered, word-addressed RAM that answers one request at a time after a configurable number of wait states.
- The core's FSM issues a request and stalls until it sees the response pulse.
- Flags misaligned and out-of-range accesses.

Parameters:
DEPTH_LOG2, 6, log2 of RAM depth in 32-bit words (default 64 words, byte range 0x000–0x0FF)
WAIT_CYCLES, 2, wait-state cycles between acceptance and response (legal 0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  input  1  request present; sampled only when req_ready=1
req_write  input  1  1 = write, 0 = read
req_adr  input  32  byte address
req_wdata  input  32  write data
req_ready  output  1  responder idle; request accepted on an edge where req_valid&&req_ready
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  read data, valid while rsp_valid=1
rsp_err  output  1  access error, valid while rsp_valid=1
busy  output  1  request in flight (state != IDLE)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request registers=0. RAM contents are not reset and keep their values across reset.
- FSM states: IDLE, WAIT, RESP.
- Outputs by state: req_ready=1 only in IDLE; busy=1 in WAIT and RESP; rsp_valid=1 only in RESP.
- IDLE: on an edge with req_valid=1, accept the request (acceptance edge E) and capture req_write, req_adr and req_wdata. Next state is WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise RESP.
- WAIT: the counter decrements each edge. On the edge where counter==0, go to RESP. This is the commit edge C=E+WAIT_CYCLES; for WAIT_CYCLES=0, C=E.
- At commit edge C:
  - Error if captured adr[1:0]!=0, or if adr[31:DEPTH_LOG2+2]!=0.
  - Error: no RAM write, rsp_rdata<=0, rsp_err<=1.
  - Good read: rsp_rdata<=RAM[adr[DEPTH_LOG2+1:2]], rsp_err<=0.
  - Good write: RAM[index]<=wdata, rsp_rdata<=wdata (echo), rsp_err<=0.
- RESP: lasts exactly one cycle. rsp_valid=1 between edges C and C+1. Next state is IDLE. No back-pressure on the response.
- rsp_rdata and rsp_err hold their values after RESP until the next commit edge.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the acceptance edge, counting E itself.
- Throughput: the earliest next acceptance is at edge E+WAIT_CYCLES+2.
- req_valid while not IDLE is ignored. The request is not queued; the requester must hold it until acceptance.
- Input changes after E have no effect on the in-flight request.
- Reset asserted before C aborts the request: no RAM write and no rsp_valid. Reset asserted during RESP clears rsp_valid immediately; the write already committed at C remains.
- Write followed by a read of the same address returns the new data. No read-during-write hazard exists because there is only one request in flight.
- Wait counter width is 4 bits. WAIT_CYCLES=0 must skip WAIT entirely, with no wrap to 15.

Test Plan:
1. Hold reset=0 → req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00000000, rsp_err=0. Release reset → req_ready stays 1.
2. WAIT_CYCLES=2: write 0x00000010←0xDEADBEEF accepted at E → rsp_valid=1 only between edges E+2 and E+3, rsp_err=0, req_ready=0 until E+3. Then read 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0.
3. Write 0x00000012←0x12345678 → rsp_err=1, rsp_rdata=0. A following read of 0x10 still returns 0xDEADBEEF.
4. Read 0x00000100 (word 64, out of range) → rsp_err=1, rsp_rdata=0. Read 0x000000FC → rsp_err=0.
5. req_valid held high continuously with alternating addresses → acceptances exactly 4 edges apart (WAIT_CYCLES+2) and exactly one rsp_valid pulse per request. Repeat with WAIT_CYCLES=0 → accepts 2 edges apart, rsp_valid in the cycle right after E.
6. Write 0x20←0xAAAA5555 completes. Then write 0x20←0x0000FFFF, and pulse reset=0 one cycle after acceptance (in WAIT) → no rsp_valid, state IDLE. A later read of 0x20 returns 0xAAAA5555.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the multicycle core's memory port: one request at a time,
// answered with a one-cycle pulse after WAIT_CYCLES wait states; flags misaligned/out-of-range.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// ST_IDLE   | ready for a request; accepts on req_valid
// ST_WAIT   | wait states counting down; commit on the edge where cnt==0
// ST_RESP   | rsp_valid high for exactly one cycle, then back to idle
module mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic                  commit;
  logic                  c_wr;
  logic [31:0]           c_adr;
  logic [31:0]           c_wdata;
  logic                  c_err;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  mem_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;

    // With zero wait states the commit happens on the acceptance edge, so the
    // live request inputs are used instead of the (not yet loaded) captures.
    c_wr    = wr_q;
    c_adr   = adr_q;
    c_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      c_wr    = req_write;
      c_adr   = req_adr;
      c_wdata = req_wdata;
    end
    c_idx = c_adr[DEPTH_LOG2+1:2];
    c_err = (c_adr[1:0] != 2'b00) || ((c_adr >> (DEPTH_LOG2 + 2)) != 32'd0);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          adr_d   = req_adr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      if (c_err) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else begin
        rdata_d = c_wr ? c_wdata : mem[c_idx];
        err_d   = 1'b0;
      end
    end

    mem_we = commit && c_wr && !c_err && reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      adr_q   <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_wdata;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
